// File: rtl/plic_pkg.sv
// Shared types and register offsets for the platform-level interrupt controller.
package plic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StInService
  } gateway_state_t;

  localparam logic [7:0] PRIO_BASE  = 8'h00;
  localparam logic [7:0] PEND_OFF   = 8'h80;
  localparam logic [7:0] EN_OFF     = 8'h84;
  localparam logic [7:0] THRESH_OFF = 8'h88;
  localparam logic [7:0] CLAIM_OFF  = 8'h8C;

  // Bits needed to encode source IDs 0..n-1.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a level request until it is claimed and then completed.
module plic_gateway
  import plic_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic irq_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  gateway_state_t state_q, state_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (irq_i)      state_d = StPending;
      StPending:   if (claim_i)    state_d = StInService;
      StInService: if (complete_i) state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  assign pending_o = (state_q == StPending);

endmodule

// File: rtl/plic_ctrl.sv
// PLIC top: register file, bus decode, priority arbiter and registered ext_int/ext_int_clear.
module plic_ctrl
  import plic_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              ren,
  input  logic              wen,
  input  logic [7:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              ext_int,
  output logic              ext_int_clear
);

  localparam int unsigned IdW = id_width(N_SRC);

  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic [N_SRC-1:0]  en_q, en_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [31:0]       rdata_d;
  logic              ack_d;

  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  claim_vec;
  logic [N_SRC-1:0]  complete_vec;
  logic [IdW-1:0]    best_id;
  logic [PRIO_W-1:0] best_prio;

  logic [5:0]        word;
  logic [5:0]        prio_idx;
  logic              rd_en;
  logic              in_prio;
  logic              hit_claim;

  assign pend[0] = 1'b0;

  for (genvar i = 1; i < N_SRC; i++) begin : g_gw
    plic_gateway u_gw (
      .CLK        (CLK),
      .RST        (RST),
      .irq_i      (irq_src[i]),
      .claim_i    (claim_vec[i]),
      .complete_i (complete_vec[i]),
      .pending_o  (pend[i])
    );
  end

  // Strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    elig      = '0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i < N_SRC; i++) begin
      elig[i] = pend[i] & en_q[i] & (prio_q[i] > thr_q);
      if (elig[i] && (prio_q[i] > best_prio)) begin
        best_id   = IdW'(i);
        best_prio = prio_q[i];
      end
    end
  end

  assign word      = addr[7:2];
  assign prio_idx  = word - PRIO_BASE[7:2];
  assign in_prio   = (word < PEND_OFF[7:2]);
  assign hit_claim = (word == CLAIM_OFF[7:2]);
  // A simultaneous write takes precedence and the read is dropped.
  assign rd_en     = ren & ~wen;

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 1; i < N_SRC; i++) begin
      claim_vec[i]    = rd_en & hit_claim & (best_id == IdW'(i));
      complete_vec[i] = wen & hit_claim & (wdata == 32'(i));
    end
  end

  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    if (wen) begin
      if (in_prio) begin
        for (int i = 1; i < N_SRC; i++) begin
          if (prio_idx == 6'(i)) prio_d[i] = wdata[PRIO_W-1:0];
        end
      end else if (word == EN_OFF[7:2]) begin
        en_d = {wdata[N_SRC-1:1], 1'b0};
      end else if (word == THRESH_OFF[7:2]) begin
        thr_d = wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    ack_d   = ren | wen;
    if (rd_en) begin
      if (in_prio) begin
        for (int i = 1; i < N_SRC; i++) begin
          if (prio_idx == 6'(i)) rdata_d = 32'(prio_q[i]);
        end
      end else if (word == PEND_OFF[7:2]) begin
        rdata_d = 32'(pend);
      end else if (word == EN_OFF[7:2]) begin
        rdata_d = 32'(en_q);
      end else if (word == THRESH_OFF[7:2]) begin
        rdata_d = 32'(thr_q);
      end else if (hit_claim) begin
        rdata_d = 32'(best_id);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
      en_q          <= '0;
      thr_q         <= '0;
      rdata         <= '0;
      ack           <= 1'b0;
      ext_int       <= 1'b0;
      ext_int_clear <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      en_q          <= en_d;
      thr_q         <= thr_d;
      rdata         <= rdata_d;
      ack           <= ack_d;
      ext_int       <= |elig;
      ext_int_clear <= ext_int & ~(|elig);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{irq_src[0], addr[1:0], claim_vec[0], complete_vec[0], prio_q[0]};

endmodule
